// File: rtl/serial_frame_ctrl_if.sv
// Bundle of the serial-side handshake and the parallel word outputs of
// serial_frame_ctrl. The source/consumer side uses master, the controller
// uses slave.
interface serial_frame_ctrl_if #(
    parameter int WORD_W = 8,
    parameter int CH_W   = 2,
    parameter int NUM_CH = 4
);
    logic              start;
    logic              sdin;
    logic              din_en;
    logic              abort;
    logic              ready;
    logic [WORD_W-1:0] dout;
    logic [CH_W-1:0]   dout_ch;
    logic              dout_valid;
    logic              dout_last;
    logic [NUM_CH-1:0] ch_sel;
    logic              busy;
    logic              done;
    logic              error;
    logic [1:0]        err_code;

    modport master (
        output start, sdin, din_en, abort,
        input  ready, dout, dout_ch, dout_valid, dout_last, ch_sel,
               busy, done, error, err_code
    );

    modport slave (
        input  start, sdin, din_en, abort,
        output ready, dout, dout_ch, dout_valid, dout_last, ch_sel,
               busy, done, error, err_code
    );
endinterface

// File: rtl/serial_frame_ctrl.sv
// Bit-serial frame receiver: length header, channel header, then payload
// words, each emitted as a parallel word tagged with its channel. Header
// errors and abort park the controller in a sticky ERROR state that only a
// new start (or rst) leaves.
module serial_frame_ctrl #(
    parameter int WORD_W = 8,
    parameter int LEN_W  = 4,
    parameter int CH_W   = 2,
    parameter int NUM_CH = 4
) (
    input logic              clk,
    input logic              rst,
    serial_frame_ctrl_if.slave bus
);
    localparam int MAX_W = (WORD_W > LEN_W) ? ((WORD_W > CH_W) ? WORD_W : CH_W)
                                            : ((LEN_W > CH_W) ? LEN_W : CH_W);
    localparam int BC_W  = $clog2(MAX_W + 1);

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_LEN0  = 2'd1;
    localparam logic [1:0] ERR_CH    = 2'd2;
    localparam logic [1:0] ERR_ABORT = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_REL,
        S_HDR_LEN,
        S_HDR_CH,
        S_CHECK,
        S_PAYLOAD,
        S_DONE,
        S_ERROR
    } state_t;

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [LEN_W-1:0]  word_cnt_q, word_cnt_d;
    logic [WORD_W-1:0] dout_q, dout_d;
    logic [CH_W-1:0]   dout_ch_q, dout_ch_d;
    logic              dout_valid_q, dout_valid_d;
    logic              dout_last_q, dout_last_d;
    logic [1:0]        err_code_q, err_code_d;

    logic              ready;
    logic              accept;
    logic [LEN_W-1:0]  len_shift;
    logic [CH_W-1:0]   ch_shift;
    logic [WORD_W-1:0] word_shift;
    logic [LEN_W-1:0]  word_cnt_inc;
    logic              ch_bad;

    // Serial acceptance qualifier and the MSB-first shift candidates.
    always_comb begin
        ready        = (state_q == S_HDR_LEN) || (state_q == S_HDR_CH) ||
                       (state_q == S_PAYLOAD);
        accept       = ready && bus.din_en;
        len_shift    = LEN_W'({len_q, bus.sdin});
        ch_shift     = CH_W'({ch_q, bus.sdin});
        word_shift   = WORD_W'({word_q, bus.sdin});
        word_cnt_inc = word_cnt_q + LEN_W'(1);
        ch_bad       = {1'b0, ch_q} >= (CH_W + 1)'(NUM_CH);
    end

    // Next-state, header/payload assembly and word emission.
    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        ch_d         = ch_q;
        word_d       = word_q;
        bit_cnt_d    = bit_cnt_q;
        word_cnt_d   = word_cnt_q;
        dout_d       = dout_q;
        dout_ch_d    = dout_ch_q;
        dout_valid_d = 1'b0;
        dout_last_d  = 1'b0;
        err_code_d   = err_code_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) state_d = S_WAIT_REL;
            end
            S_WAIT_REL: begin
                bit_cnt_d = '0;
                if (!bus.start) state_d = S_HDR_LEN;
            end
            S_HDR_LEN: begin
                if (bus.abort) begin
                    state_d    = S_ERROR;
                    err_code_d = ERR_ABORT;
                end else if (accept) begin
                    len_d = len_shift;
                    if (bit_cnt_q == BC_W'(LEN_W - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = S_HDR_CH;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BC_W'(1);
                    end
                end
            end
            S_HDR_CH: begin
                if (bus.abort) begin
                    state_d    = S_ERROR;
                    err_code_d = ERR_ABORT;
                end else if (accept) begin
                    ch_d = ch_shift;
                    if (bit_cnt_q == BC_W'(CH_W - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = S_CHECK;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BC_W'(1);
                    end
                end
            end
            S_CHECK: begin
                // Abort first, then zero length, then channel range.
                if (bus.abort) begin
                    state_d    = S_ERROR;
                    err_code_d = ERR_ABORT;
                end else if (len_q == '0) begin
                    state_d    = S_ERROR;
                    err_code_d = ERR_LEN0;
                end else if (ch_bad) begin
                    state_d    = S_ERROR;
                    err_code_d = ERR_CH;
                end else begin
                    state_d    = S_PAYLOAD;
                    word_cnt_d = '0;
                    bit_cnt_d  = '0;
                    dout_ch_d  = ch_q;
                end
            end
            S_PAYLOAD: begin
                // Abort wins over a completing bit: no word is emitted.
                if (bus.abort) begin
                    state_d    = S_ERROR;
                    err_code_d = ERR_ABORT;
                end else if (accept) begin
                    word_d = word_shift;
                    if (bit_cnt_q == BC_W'(WORD_W - 1)) begin
                        bit_cnt_d    = '0;
                        dout_d       = word_shift;
                        dout_valid_d = 1'b1;
                        word_cnt_d   = word_cnt_inc;
                        if (word_cnt_inc == len_q) begin
                            dout_last_d = 1'b1;
                            state_d     = S_DONE;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BC_W'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_ERROR: begin
                if (bus.start) begin
                    state_d    = S_WAIT_REL;
                    err_code_d = ERR_NONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; rst clears everything, data included.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            len_q        <= '0;
            ch_q         <= '0;
            word_q       <= '0;
            bit_cnt_q    <= '0;
            word_cnt_q   <= '0;
            dout_q       <= '0;
            dout_ch_q    <= '0;
            dout_valid_q <= 1'b0;
            dout_last_q  <= 1'b0;
            err_code_q   <= ERR_NONE;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            ch_q         <= ch_d;
            word_q       <= word_d;
            bit_cnt_q    <= bit_cnt_d;
            word_cnt_q   <= word_cnt_d;
            dout_q       <= dout_d;
            dout_ch_q    <= dout_ch_d;
            dout_valid_q <= dout_valid_d;
            dout_last_q  <= dout_last_d;
            err_code_q   <= err_code_d;
        end
    end

    // Status outputs decoded from the state, plus the one-hot channel select.
    always_comb begin
        bus.ready      = ready;
        bus.dout       = dout_q;
        bus.dout_ch    = dout_ch_q;
        bus.dout_valid = dout_valid_q;
        bus.dout_last  = dout_last_q;
        bus.busy       = (state_q != S_IDLE) && (state_q != S_ERROR);
        bus.done       = (state_q == S_DONE);
        bus.error      = (state_q == S_ERROR);
        bus.err_code   = err_code_q;
        for (int i = 0; i < NUM_CH; i++) begin
            bus.ch_sel[i] = ((state_q == S_PAYLOAD) || (state_q == S_DONE)) &&
                            (dout_ch_q == CH_W'(i));
        end
    end
endmodule

// File: tb/tb_serial_frame_ctrl.sv
// Scoreboard bench for serial_frame_ctrl: the driver pushes each expected
// word (value, channel, last flag, cycle of appearance) as it sends the
// word's final bit; a negedge monitor pops and compares on every dout_valid.
module tb_serial_frame_ctrl;
    localparam int WORD_W = 8;
    localparam int LEN_W  = 4;
    localparam int CH_W   = 2;

    typedef struct {
        logic [7:0] w;
        logic [1:0] ch;
        logic       last;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];
    exp_t e;
    logic [7:0] frame_words [16];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    serial_frame_ctrl_if #(.WORD_W(WORD_W), .CH_W(CH_W), .NUM_CH(4)) a_if ();
    serial_frame_ctrl_if #(.WORD_W(WORD_W), .CH_W(CH_W), .NUM_CH(3)) b_if ();

    // Second instance (NUM_CH=3) sees the same serial stimulus.
    assign b_if.start  = a_if.start;
    assign b_if.sdin   = a_if.sdin;
    assign b_if.din_en = a_if.din_en;
    assign b_if.abort  = a_if.abort;

    serial_frame_ctrl #(.WORD_W(WORD_W), .LEN_W(LEN_W), .CH_W(CH_W), .NUM_CH(4)) dut_a (
        .clk(clk),
        .rst(rst),
        .bus(a_if)
    );

    serial_frame_ctrl #(.WORD_W(WORD_W), .LEN_W(LEN_W), .CH_W(CH_W), .NUM_CH(3)) dut_b (
        .clk(clk),
        .rst(rst),
        .bus(b_if)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every dout_valid pulse must match the head of the scoreboard.
    always begin
        @(negedge clk);
        if (a_if.dout_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_dout_valid", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("dout", 32'(a_if.dout), 32'(e.w));
                chk("dout_ch", 32'(a_if.dout_ch), 32'(e.ch));
                chk("dout_last", 32'(a_if.dout_last), 32'(e.last));
                chk("done_with_pulse", 32'(a_if.done), 32'(e.last));
                chk("ch_sel", 32'(a_if.ch_sel), 32'(4'b0001 << e.ch));
                chk("pulse_cycle", 32'(cyc), 32'(e.cyc));
            end
        end else if (a_if.done === 1'b1) begin
            chk("done_without_pulse", 32'd1, 32'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b, input bit gap, output int dcyc);
        if (gap) begin
            repeat (2) begin
                a_if.din_en = 1'b0;
                a_if.sdin   = 1'($urandom_range(0, 1));
                tick();
            end
        end
        a_if.din_en = 1'b1;
        a_if.sdin   = b;
        dcyc        = cyc;
        tick();
        a_if.din_en = 1'b0;
    endtask

    task automatic send_hdr(input logic [3:0] len, input logic [1:0] ch, input bit gap);
        int d;
        a_if.start = 1'b1;
        tick();
        a_if.start = 1'b0;
        tick();
        for (int i = 3; i >= 0; i--) drive_bit(len[i], gap, d);
        for (int i = 1; i >= 0; i--) drive_bit(ch[i], gap, d);
        // CHECK cycle: din_en high with garbage must be ignored
        a_if.din_en = 1'b1;
        a_if.sdin   = 1'b1;
        tick();
        a_if.din_en = 1'b0;
    endtask

    task automatic send_words(input int n, input int len, input logic [1:0] ch, input bit gap);
        int   d;
        exp_t x;
        for (int w = 0; w < n; w++) begin
            for (int b = 7; b >= 0; b--) begin
                drive_bit(frame_words[w][b], gap, d);
            end
            x.w    = frame_words[w];
            x.ch   = ch;
            x.last = (w == len - 1);
            x.cyc  = d + 1;
            sb.push_back(x);
        end
    endtask

    task automatic run_frame(input logic [3:0] len, input logic [1:0] ch, input bit gap);
        send_hdr(len, ch, gap);
        send_words(int'(len), int'(len), ch, gap);
        repeat (3) tick();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ready"}, 32'(a_if.ready), 32'd0);
        chk({tag, "_dout"}, 32'(a_if.dout), 32'd0);
        chk({tag, "_dout_ch"}, 32'(a_if.dout_ch), 32'd0);
        chk({tag, "_dout_valid"}, 32'(a_if.dout_valid), 32'd0);
        chk({tag, "_dout_last"}, 32'(a_if.dout_last), 32'd0);
        chk({tag, "_ch_sel"}, 32'(a_if.ch_sel), 32'd0);
        chk({tag, "_busy"}, 32'(a_if.busy), 32'd0);
        chk({tag, "_done"}, 32'(a_if.done), 32'd0);
        chk({tag, "_error"}, 32'(a_if.error), 32'd0);
        chk({tag, "_err_code"}, 32'(a_if.err_code), 32'd0);
    endtask

    initial begin
        int d;
        rst         = 1'b1;
        a_if.start  = 1'b0;
        a_if.sdin   = 1'b0;
        a_if.din_en = 1'b0;
        a_if.abort  = 1'b0;
        repeat (2) tick();
        check_zero("reset");
        rst = 1'b0;
        tick();

        // Basic frame: len=2, ch=1, words A5 and 3C, continuous din_en
        frame_words[0] = 8'hA5;
        frame_words[1] = 8'h3C;
        run_frame(4'd2, 2'd1, 1'b0);

        // Same frame with two-cycle din_en gaps and garbage sdin
        run_frame(4'd2, 2'd1, 1'b1);

        // Zero length header
        send_hdr(4'd0, 2'd0, 1'b0);
        chk("len0_error", 32'(a_if.error), 32'd1);
        chk("len0_err_code", 32'(a_if.err_code), 32'd1);
        chk("len0_ready", 32'(a_if.ready), 32'd0);
        chk("len0_busy", 32'(a_if.busy), 32'd0);
        tick();
        chk("len0_err_code_held", 32'(a_if.err_code), 32'd1);
        a_if.start = 1'b1;
        tick();
        chk("restart_error_clear", 32'(a_if.error), 32'd0);
        chk("restart_err_code_clear", 32'(a_if.err_code), 32'd0);
        chk("restart_busy", 32'(a_if.busy), 32'd1);
        frame_words[0] = 8'h5A;
        frame_words[1] = 8'hC3;
        run_frame(4'd2, 2'd1, 1'b0);

        // Channel out of range on the NUM_CH=3 instance; the NUM_CH=4 one accepts it
        send_hdr(4'd1, 2'd3, 1'b0);
        chk("badch_b_error", 32'(b_if.error), 32'd1);
        chk("badch_b_err_code", 32'(b_if.err_code), 32'd2);
        chk("badch_b_ch_sel", 32'(b_if.ch_sel), 32'd0);
        chk("badch_a_ch_sel", 32'(a_if.ch_sel), 32'h8);
        chk("badch_a_busy", 32'(a_if.busy), 32'd1);
        tick();
        chk("badch_b_ch_sel_hold", 32'(b_if.ch_sel), 32'd0);
        a_if.abort = 1'b1;
        tick();
        a_if.abort = 1'b0;
        chk("abort_payload_err_code", 32'(a_if.err_code), 32'd3);
        chk("abort_ignored_in_error", 32'(b_if.err_code), 32'd2);

        // Abort on the cycle that accepts the 8th bit of word 0
        send_hdr(4'd2, 2'd1, 1'b0);
        frame_words[0] = 8'hA5;
        for (int b = 7; b >= 1; b--) drive_bit(frame_words[0][b], 1'b0, d);
        a_if.din_en = 1'b1;
        a_if.sdin   = frame_words[0][0];
        a_if.abort  = 1'b1;
        tick();
        a_if.abort  = 1'b0;
        a_if.din_en = 1'b0;
        chk("abort8_error", 32'(a_if.error), 32'd1);
        chk("abort8_err_code", 32'(a_if.err_code), 32'd3);
        chk("abort8_ready", 32'(a_if.ready), 32'd0);
        chk("abort8_dout_valid", 32'(a_if.dout_valid), 32'd0);
        tick();
        chk("abort8_dout_valid_next", 32'(a_if.dout_valid), 32'd0);

        // rst in the middle of PAYLOAD (after one full word, mid second word)
        frame_words[0] = 8'h81;
        send_hdr(4'd2, 2'd2, 1'b0);
        send_words(1, 2, 2'd2, 1'b0);
        for (int b = 7; b >= 5; b--) drive_bit(1'b1, 1'b0, d);
        rst = 1'b1;
        tick();
        check_zero("midrst");
        rst = 1'b0;
        tick();

        // Maximum length frame: 15 words, dout_last only on the 15th
        for (int i = 0; i < 15; i++) frame_words[i] = 8'((i * 37) + 11);
        run_frame(4'd15, 2'd0, 1'b0);

        repeat (4) tick();
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/serial_frame_ctrl.md
Name: serial_frame_ctrl

Overview:
- Parametrised successor to the midterm serial-decoder controller. Receives a bit-serial frame: length header, then channel header, then payload words.
- Assembles payload words internally and emits each as a parallel word tagged with its channel, plus a one-hot channel select.
- Adds recoverable error handling (header checks, abort) and a bit-enable qualifier so the source may stall.
- Sits between the serial input pin logic and the per-channel output registers.

Parameters:
- WORD_W, 8: payload word width in bits (≥1).
- LEN_W, 4: width of the length field; legal frame length is 1..2^LEN_W−1 words.
- CH_W, 2: width of the channel field (≥1).
- NUM_CH, 4: number of channels; must satisfy NUM_CH ≤ 2^CH_W.

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high; clock clk
- start  in  1  frame start level; a frame begins on its release
- sdin  in  1  serial data bit, MSB first
- din_en  in  1  sdin valid this cycle; a bit is accepted only when din_en=1 and ready=1
- abort  in  1  cancel the current frame
- ready  out  1  controller is accepting serial bits
- dout  out  WORD_W  last assembled payload word (holds between words)
- dout_ch  out  CH_W  latched channel of the current frame
- dout_valid  out  1  one-cycle pulse: dout is a new word
- dout_last  out  1  high together with dout_valid on the final word of the frame
- ch_sel  out  NUM_CH  one-hot of dout_ch in PAYLOAD/DONE, else 0
- busy  out  1  state is not IDLE and not ERROR
- done  out  1  one-cycle pulse on frame completion
- error  out  1  high while in ERROR
- err_code  out  2  0 = none, 1 = zero length, 2 = bad channel, 3 = aborted; held while in ERROR

Behaviour:
- Reset: state IDLE. All outputs 0, including dout, dout_ch, and internal len/ch/word/bit counters.
- States: IDLE, WAIT_REL, HDR_LEN, HDR_CH, CHECK, PAYLOAD, DONE, ERROR.
- IDLE → WAIT_REL when start=1.
- WAIT_REL holds while start=1; start=0 → HDR_LEN. Bit counter is cleared.
- HDR_LEN: ready=1. Each accepted bit shifts into len (MSB first). The LEN_W-th accepted bit moves to HDR_CH and clears the bit counter.
- HDR_CH: ready=1. Bits shift into ch the same way. The CH_W-th accepted bit moves to CHECK.
- CHECK: ready=0, exactly one cycle. Checks in priority order:
  - len==0 → ERROR, code 1.
  - ch≥NUM_CH → ERROR, code 2.
  - otherwise → PAYLOAD, with word counter=0 and dout_ch loaded with ch.
- PAYLOAD: ready=1. Accepted bits shift into the word register.
  - On the edge ending the cycle that accepts the WORD_W-th bit: dout loads the full word (including that bit), dout_valid=1 for the following cycle, word counter increments, bit counter clears.
  - If the incremented count equals len, dout_last=1 with that pulse and state → DONE.
- Latency: the word appears on dout exactly 1 cycle after its last bit is accepted. ready=0 during that DONE cycle.
- DONE: done=1 for one cycle → IDLE. The final dout_valid/dout_last pulse and done are in the same cycle.
- ERROR: error=1 and err_code held; ready=0; no dout_valid. Sticky until start=1, which clears error/err_code and goes → WAIT_REL. rst also exits.
- abort=1 in HDR_LEN, HDR_CH, CHECK or PAYLOAD → ERROR, code 3.
  - abort beats a bit accept or word completion in the same cycle: no dout_valid is issued.
  - abort is ignored in IDLE, WAIT_REL, DONE and ERROR.
- start in HDR_LEN..DONE is ignored.
- din_en=1 while ready=0 is ignored; no counter changes.
- din_en gaps of any length stall the state without losing partial bits.
- dout_valid is never asserted for a partial word.
- Counter widths:
  - Bit counter: clog2(max(WORD_W, LEN_W, CH_W)+1).
  - Word counter: LEN_W. Comparisons are unsigned.
  - Maximum len=2^LEN_W−1 completes without wrap.
- rst mid-frame: returns to IDLE next edge with all outputs 0. The partial frame is discarded.

Test Plan:
- Defaults; start 1 cycle then low; continuous din_en bits 0010, 01, 10100101, 00111100 → dout_valid twice, dout=0xA5 then 0x3C. Second pulse has dout_last=1 and done=1 in the same cycle. dout_ch=1, ch_sel=0010. Each pulse is exactly 1 cycle after that word's 8th bit.
- Same frame with din_en toggling 1,0,0,1,… plus ignored sdin garbage while din_en=0 → identical words, delayed only by the gaps.
- Header len=0000, ch=00 → error=1, err_code=1 the cycle after CHECK, no dout_valid. Then start=1 → error=0 and a new frame is received correctly.
- NUM_CH=3 override, ch=11, len=1 → err_code=2, ch_sel stays 000.
- abort=1 on the cycle accepting the 8th bit of word 0 → no dout_valid, err_code=3, ready=0.
- rst asserted mid-PAYLOAD → next cycle all outputs 0, state IDLE. len=15 frame afterward → 15 pulses, dout_last only on the 15th.
